// File: rtl/mips_instr_encoder_if.sv
// Bus interfaces for the MIPS instruction encoder: descriptor intake from the host
// and the stall-capable instruction-memory write port.
interface mips_desc_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

interface mips_imem_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_gnt;

    modport master (output imem_req, imem_addr, imem_wdata, input imem_gnt);
    modport slave  (input imem_req, imem_addr, imem_wdata, output imem_gnt);
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS descriptors into machine words, buffers them in a small FIFO
// and writes them to consecutive instruction-memory addresses.
module mips_instr_encoder #(
    parameter int                ADDR_W     = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    mips_desc_if.slave  desc,
    mips_imem_if.master imem,
    output logic        done_o,
    output logic        err_o,
    output logic        wrap_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    // ---------------- encoder ----------------
    logic [5:0]  op_c, funct_c;
    logic [4:0]  rs_c, rt_c, rd_c, shamt_c;
    logic [1:0]  fmt_c;
    logic        illegal_c;
    logic [31:0] enc_word;

    always_comb begin
        op_c      = 6'h00;
        funct_c   = 6'h00;
        rs_c      = desc.in_rs;
        rt_c      = desc.in_rt;
        rd_c      = desc.in_rd;
        shamt_c   = 5'd0;
        fmt_c     = FMT_R;
        illegal_c = 1'b0;
        case (desc.in_mnem)
            5'd0:  begin op_c = 6'h23; fmt_c = FMT_I; end
            5'd1:  begin op_c = 6'h2b; fmt_c = FMT_I; end
            5'd2:  begin op_c = 6'h0f; fmt_c = FMT_I; rs_c = 5'd0; end
            5'd3:  funct_c = 6'h20;
            5'd4:  funct_c = 6'h21;
            5'd5:  funct_c = 6'h22;
            5'd6:  funct_c = 6'h23;
            5'd7:  begin op_c = 6'h08; fmt_c = FMT_I; end
            5'd8:  begin op_c = 6'h09; fmt_c = FMT_I; end
            5'd9:  funct_c = 6'h24;
            5'd10: funct_c = 6'h25;
            5'd11: funct_c = 6'h26;
            5'd12: funct_c = 6'h27;
            5'd13: begin op_c = 6'h0c; fmt_c = FMT_I; end
            5'd14: begin funct_c = 6'h00; rs_c = 5'd0; shamt_c = desc.in_shamt; end
            5'd15: begin funct_c = 6'h02; rs_c = 5'd0; shamt_c = desc.in_shamt; end
            5'd16: begin funct_c = 6'h03; rs_c = 5'd0; shamt_c = desc.in_shamt; end
            5'd17: funct_c = 6'h2a;
            5'd18: funct_c = 6'h2b;
            5'd19: begin op_c = 6'h0a; fmt_c = FMT_I; end
            5'd20: begin op_c = 6'h0b; fmt_c = FMT_I; end
            5'd21: begin op_c = 6'h04; fmt_c = FMT_I; end
            5'd22: begin op_c = 6'h02; fmt_c = FMT_J; end
            5'd23: begin op_c = 6'h03; fmt_c = FMT_J; end
            5'd24: begin funct_c = 6'h08; rt_c = 5'd0; rd_c = 5'd0; end
            5'd25: begin funct_c = 6'h09; rt_c = 5'd0; end
            default: illegal_c = 1'b1;
        endcase

        case (fmt_c)
            FMT_R:   enc_word = {op_c, rs_c, rt_c, rd_c, shamt_c, funct_c};
            FMT_I:   enc_word = {op_c, rs_c, rt_c, desc.in_imm};
            default: enc_word = {op_c, desc.in_target};
        endcase
        // Illegal mnemonics still occupy a slot, as a nop.
        if (illegal_c) enc_word = 32'h0000_0000;
    end

    // ---------------- FIFO of {word, last} ----------------
    logic [31:0]           fifo_word_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PW:0]           wptr_q, rptr_q;
    logic [PW:0]           cnt;
    logic [PW-1:0]         rd_idx, rd_idx_nxt;
    logic                  full, empty, push, pop;
    logic [31:0]           head_word, next_word;
    logic                  head_last;

    assign cnt        = wptr_q - rptr_q;
    assign full       = (cnt == CW'(FIFO_DEPTH));
    assign empty      = (cnt == '0);
    assign rd_idx     = rptr_q[PW-1:0];
    assign rd_idx_nxt = rd_idx + PW'(1);
    assign head_word  = fifo_word_q[rd_idx];
    assign head_last  = fifo_last_q[rd_idx];
    assign next_word  = fifo_word_q[rd_idx_nxt];

    assign desc.in_ready = reset_n_i & ~full;
    assign push          = desc.in_valid & desc.in_ready;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + CW'(1);
            if (pop)  rptr_q <= rptr_q + CW'(1);
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_word_q[wptr_q[PW-1:0]] <= enc_word;
            fifo_last_q[wptr_q[PW-1:0]] <= desc.in_last;
        end
    end

    // ---------------- writer FSM ----------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wrap_d  = wrap_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_REQ;
                    wdata_d = head_word;
                end
            end
            S_REQ: begin
                if (imem.imem_gnt) begin
                    pop    = 1'b1;
                    wrap_d = wrap_q | (&addr_q);
                    if (head_last) begin
                        state_d = S_DONE;
                        addr_d  = BASE_ADDR;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        // Keep streaming when another word remains after this pop,
                        // including one arriving on this very edge.
                        if (cnt > CW'(1)) begin
                            wdata_d = next_word;
                        end else if (push) begin
                            wdata_d = enc_word;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign err_d = err_q | (push & illegal_c);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign imem.imem_req   = (state_q == S_REQ);
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign done_o          = (state_q == S_DONE);
    assign err_o           = err_q;
    assign wrap_o          = wrap_q;
endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Encodes symbolic MIPS instruction descriptors (mnemonic ID plus register/immediate fields) into 32-bit machine words and writes them to consecutive instruction-memory addresses. It sits between a test/boot host and the single-cycle core's instruction memory, and is the encoding counterpart of the core's opcode/funct control decode. A small FIFO decouples descriptor intake from a stall-capable memory write port.

## Interface
- ADDR_W, 8: instruction-memory word-address width.
- FIFO_DEPTH, 4: encoded-word buffer depth; must be a power of two, ≥2.
- BASE_ADDR, 0: first word address of every program.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  descriptor present.
- in_ready  out  1  block can accept the descriptor.
- in_mnem  in  5  mnemonic ID: 0 lw, 1 sw, 2 lui, 3 add, 4 addu, 5 sub, 6 subu, 7 addi, 8 addiu, 9 and, 10 or, 11 xor, 12 nor, 13 andi, 14 sll, 15 srl, 16 sra, 17 slt, 18 sltu, 19 slti, 20 sltiu, 21 beq, 22 j, 23 jal, 24 jr, 25 jalr; 26–31 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target field.
- in_last  in  1  descriptor is the final instruction of the program.
- imem_req  out  1  write request.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- imem_gnt  in  1  memory accepted the write this cycle.
- done  out  1  one-cycle pulse after the last word is granted.
- err  out  1  sticky: an illegal mnemonic was received.
- wrap  out  1  sticky: address counter wrapped past all-ones.

## Operation
- Opcodes: lw 0x23, sw 0x2b, lui 0x0f, addi 0x08, addiu 0x09, andi 0x0c, slti 0x0a, sltiu 0x0b, beq 0x04, j 0x02, jal 0x03; all others in the R-type group use opcode 0x00.
- Funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, sll 0x00, srl 0x02, sra 0x03, slt 0x2a, sltu 0x2b, jr 0x08, jalr 0x09.
- R-type word is {op, rs, rt, rd, shamt, funct}. I-type is {op, rs, rt, imm}. J-type is {op, target}.
- Forced-zero fields, whatever the input value:
  - shamt is 0 for all non-shift R-type.
  - rs is 0 for sll/srl/sra.
  - rt, rd and shamt are 0 for jr.
  - rt and shamt are 0 for jalr.
  - rs is 0 for lui.
- Illegal mnemonic: the descriptor is still accepted and enqueued as 0x00000000 (nop). err sets and stays set until reset. in_last is honoured.
- Each FIFO entry holds {word, last}. It is pushed on in_valid & in_ready. in_ready = !full; it is not dependent on imem_gnt.
- Writer FSM:
  - IDLE → REQ when the FIFO is non-empty.
  - REQ: imem_req=1; imem_addr and imem_wdata are registered and held stable until imem_gnt.
  - On gnt: pop the entry and increment the address.
    - If the popped entry is last: go to DONE and reload the address with BASE_ADDR.
    - Else if the FIFO is still non-empty: stay in REQ with the next word (no bubble).
    - Else: go to IDLE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Address increments modulo 2^ADDR_W. The increment from all-ones to 0 sets wrap (sticky).
- Simultaneous push and pop when full: the push is refused (in_ready was 0); the pop proceeds.

## Timing
- Reset (async assert, any cycle, including mid-request): in_ready=0 while reset_n=0, then 1; imem_req=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, err=0, wrap=0; FIFO emptied; FSM IDLE. Words in flight are discarded.
- Latency: a descriptor accepted at edge k into an empty FIFO with FSM IDLE produces imem_req=1 after edge k+1.
- Sustained throughput is 1 word/cycle while imem_gnt is held high.
- imem_req never drops without a gnt. Outputs change only after the granting edge.

## Test plan
- add rd=3, rs=1, rt=2, shamt=5 at BASE_ADDR=0, gnt tied 1 -> imem_wdata=0x00221820 at addr 0, one cycle after acceptance.
- lw rt=8, rs=29, imm=4, then sw rt=8, rs=29, imm=8 back-to-back -> 0x8FA80004 @0 and 0xAFA80008 @1 on consecutive cycles.
- sll rd=2, rt=3, shamt=4, rs=7; then lui rt=1, imm=0x1234, rs=5 -> 0x00031100 and 0x3C011234.
- j target 0x10, jal target 0x3FFFFFF (last) -> 0x08000010, 0x0FFFFFFF, then done pulse; the next program starts at addr 0.
- Hold gnt=0 for 10 cycles and push 6 descriptors -> in_ready drops after 4 accepts; req, addr and data stay stable; all 6 are written in order once gnt returns.
- mnem=30 with last=1 -> 0x00000000 written, err=1, done pulses. ADDR_W=2 with 5 writes -> wrap=1 and the 5th word lands at addr 0. Assert reset_n low mid-REQ -> imem_req=0 immediately.
